uctl_cmdif_master: RTL and testbench

Initiator for the cmd interface that runs one complete write or read burst against a cmd-interface responder, such as the endpoint-data bridge. A DMA or register engine supplies a burst descriptor (start address, direction, word count). The block then drives the address phase, the per-word data handshakes, and the terminating `cmdIf_trEn` drop. Sits in the `sys_clk` domain between the local data engine and the cmd interface.

---
 rtl/uctl_cmdif_pkg.sv | 18 +
 rtl/uctl_cmdif_master.sv | 177 +++++++++++++++++
 tb/tb_uctl_cmdif_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uctl_cmdif_pkg.sv
// rtl/uctl_cmdif_pkg.sv - shared state and error encodings for the cmd interface master
package uctl_cmdif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_END   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_TMO   = 2'b01,
    ERR_ABORT = 2'b10
  } errCode_t;

endpackage

// File: rtl/uctl_cmdif_master.sv
// rtl/uctl_cmdif_master.sv - cmd interface initiator running one write or read burst per start
module uctl_cmdif_master
  import uctl_cmdif_pkg::*;
#(
  parameter int LEN_W = 11,
  parameter int TMO_W = 10
) (
  input  logic             sys_clk,
  input  logic             sysRst_n,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic             start_wrRd,
  input  logic [LEN_W-1:0] start_len,
  input  logic             abort,
  input  logic             src_valid,
  input  logic [31:0]      src_data,
  output logic             src_ready,
  output logic             dst_valid,
  output logic [31:0]      dst_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic             cmdIf_trEn,
  output logic             cmdIf_req,
  output logic             cmdIf_wrRd,
  output logic [31:0]      cmdIf_addr,
  input  logic             cmdIf_ack,
  output logic             cmdIf_wrData_req,
  output logic [31:0]      cmdIf_wrData,
  input  logic             cmdIf_wrData_ack,
  output logic             cmdIf_rdData_req,
  input  logic             cmdIf_rdData_ack,
  input  logic [31:0]      cmdIf_rdData
);

  // Timeout fires on the idle cycle that would bring the counter to all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state, nextState;
  errCode_t         errReg, errNext;
  logic [31:0]      addrReg;
  logic             wrRdReg;
  logic [LEN_W-1:0] remaining;
  logic [TMO_W-1:0] tmoCnt;
  logic             dstValidReg;

  logic inAddr, inWdata, inRdata;
  logic addrAck, wrAck, rdAck, anyAck;
  logic lastWord, tmoIdle, tmoFire, startBurst;

  assign inAddr  = (state == ST_ADDR);
  assign inWdata = (state == ST_WDATA);
  assign inRdata = (state == ST_RDATA);

  assign addrAck  = inAddr  & cmdIf_ack;
  assign wrAck    = inWdata & cmdIf_wrData_ack;
  assign rdAck    = inRdata & cmdIf_rdData_ack;
  assign anyAck   = addrAck | wrAck | rdAck;
  assign lastWord = (remaining == LEN_ONE);

  // Write phase only waits on the responder while it is actually being asked for a word.
  assign tmoIdle = (inAddr  & ~cmdIf_ack)
                 | (inWdata & src_valid & ~cmdIf_wrData_ack)
                 | (inRdata & ~cmdIf_rdData_ack);
  assign tmoFire = tmoIdle & (tmoCnt == TMO_LAST);

  assign startBurst = (state == ST_IDLE) & start & (start_len != '0);

  // State and error register.
  always_ff @(posedge sys_clk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state  <= ST_IDLE;
      errReg <= ERR_OK;
    end else begin
      state  <= nextState;
      errReg <= errNext;
    end
  end

  // Next-state and error code; abort outranks ack and timeout.
  always_comb begin
    nextState = state;
    errNext   = errReg;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          errNext   = ERR_OK;
          nextState = (start_len == '0) ? ST_END : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (abort) begin
          errNext   = ERR_ABORT;
          nextState = ST_END;
        end else if (cmdIf_ack) begin
          nextState = wrRdReg ? ST_WDATA : ST_RDATA;
        end else if (tmoFire) begin
          errNext   = ERR_TMO;
          nextState = ST_END;
        end
      end
      ST_WDATA: begin
        if (abort) begin
          errNext   = ERR_ABORT;
          nextState = ST_END;
        end else if (wrAck && lastWord) begin
          nextState = ST_END;
        end else if (tmoFire) begin
          errNext   = ERR_TMO;
          nextState = ST_END;
        end
      end
      ST_RDATA: begin
        if (abort) begin
          errNext   = ERR_ABORT;
          nextState = ST_END;
        end else if (rdAck && lastWord) begin
          nextState = ST_END;
        end else if (tmoFire) begin
          errNext   = ERR_TMO;
          nextState = ST_END;
        end
      end
      ST_END:  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Burst descriptor capture, word countdown, ack timeout and read-valid delay.
  always_ff @(posedge sys_clk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      addrReg     <= '0;
      wrRdReg     <= 1'b0;
      remaining   <= '0;
      tmoCnt      <= '0;
      dstValidReg <= 1'b0;
    end else begin
      if (startBurst) begin
        addrReg   <= start_addr;
        wrRdReg   <= start_wrRd;
        remaining <= start_len;
      end else if ((wrAck | rdAck) && (remaining != '0)) begin
        remaining <= remaining - LEN_ONE;
      end

      if (anyAck || (nextState != state)) begin
        tmoCnt <= '0;
      end else if (tmoIdle) begin
        tmoCnt <= tmoCnt + TMO_ONE;
      end

      dstValidReg <= rdAck;
    end
  end

  // Address and direction come straight from the descriptor registers so they stay
  // put for the whole burst, including the END cycle the responder still looks at.
  assign cmdIf_addr = addrReg;
  assign cmdIf_wrRd = wrRdReg;

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_END);
  assign err        = errReg;
  assign cmdIf_trEn = inAddr | inWdata | inRdata;
  assign cmdIf_req  = inAddr;

  assign cmdIf_wrData_req = inWdata & src_valid;
  assign cmdIf_wrData     = inWdata ? src_data : '0;
  assign src_ready        = wrAck;

  assign cmdIf_rdData_req = inRdata & (remaining != '0);
  assign dst_valid        = dstValidReg;
  assign dst_data         = dstValidReg ? cmdIf_rdData : '0;

endmodule

// File: tb/tb_uctl_cmdif_master.sv
// tb/tb_uctl_cmdif_master.sv - self-checking bench for uctl_cmdif_master with a responder/source model
module tb_uctl_cmdif_master;

  localparam int LEN_W = 11;
  localparam int TMO_W = 10;

  logic             sys_clk;
  logic             sysRst_n;
  logic             start;
  logic [31:0]      start_addr;
  logic             start_wrRd;
  logic [LEN_W-1:0] start_len;
  logic             abort;
  logic             src_valid;
  logic [31:0]      src_data;
  logic             src_ready;
  logic             dst_valid;
  logic [31:0]      dst_data;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic             cmdIf_trEn;
  logic             cmdIf_req;
  logic             cmdIf_wrRd;
  logic [31:0]      cmdIf_addr;
  logic             cmdIf_ack;
  logic             cmdIf_wrData_req;
  logic [31:0]      cmdIf_wrData;
  logic             cmdIf_wrData_ack;
  logic             cmdIf_rdData_req;
  logic             cmdIf_rdData_ack;
  logic [31:0]      cmdIf_rdData;

  int vectors;
  int miscompares;

  uctl_cmdif_master #(.LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
    .sys_clk          (sys_clk),
    .sysRst_n         (sysRst_n),
    .start            (start),
    .start_addr       (start_addr),
    .start_wrRd       (start_wrRd),
    .start_len        (start_len),
    .abort            (abort),
    .src_valid        (src_valid),
    .src_data         (src_data),
    .src_ready        (src_ready),
    .dst_valid        (dst_valid),
    .dst_data         (dst_data),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .cmdIf_trEn       (cmdIf_trEn),
    .cmdIf_req        (cmdIf_req),
    .cmdIf_wrRd       (cmdIf_wrRd),
    .cmdIf_addr       (cmdIf_addr),
    .cmdIf_ack        (cmdIf_ack),
    .cmdIf_wrData_req (cmdIf_wrData_req),
    .cmdIf_wrData     (cmdIf_wrData),
    .cmdIf_wrData_ack (cmdIf_wrData_ack),
    .cmdIf_rdData_req (cmdIf_rdData_req),
    .cmdIf_rdData_ack (cmdIf_rdData_ack),
    .cmdIf_rdData     (cmdIf_rdData)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idleInputs();
    start            = 1'b0;
    start_addr       = '0;
    start_wrRd       = 1'b0;
    start_len        = '0;
    abort            = 1'b0;
    src_valid        = 1'b0;
    src_data         = '0;
    cmdIf_ack        = 1'b0;
    cmdIf_wrData_ack = 1'b0;
    cmdIf_rdData_ack = 1'b0;
    cmdIf_rdData     = '0;
  endtask

  // One burst against a modelled responder. Expectations: words accepted are the source
  // words in order (one per responder ack), read words come out one cycle after their ack,
  // done comes exactly once, the cycle after the last ack or the abort.
  task automatic runBurst(input logic [31:0] addr, input logic wr, input int len,
                          input int abortAfter, input int ackPct, input int srcPct,
                          input bit fixedData, input string name);
    logic [31:0] srcWords[$];
    logic [31:0] rdWords[$];
    logic [31:0] gotWords[$];
    logic [31:0] dstWords[$];
    int   srcIdx    = 0;
    int   rdIdx     = 0;
    int   acked     = 0;
    int   cyc       = 0;
    int   doneCnt   = 0;
    int   doneCyc   = -1;
    int   lastEvt   = -1;
    bit   prevRdAck = 1'b0;
    bit   aborted   = 1'b0;
    bit   addrBad   = 1'b0;
    bit   endBad    = 1'b0;
    bit   endDst    = 1'b0;
    logic [1:0] gotErr = 2'b11;
    logic [1:0] expErr;

    for (int i = 0; i < len; i++) begin
      srcWords.push_back(fixedData ? 32'(32'hA0 + i) : $urandom);
      rdWords.push_back(fixedData ? 32'(32'h11 * (i + 1)) : $urandom);
    end
    expErr = (abortAfter >= 0) ? 2'b10 : 2'b00;

    start      = 1'b1;
    start_addr = addr;
    start_wrRd = wr;
    start_len  = LEN_W'(len);
    tick();
    start = 1'b0;
    cyc   = 1;

    while (doneCnt == 0 && cyc < 3000) begin
      abort            = 1'b0;
      cmdIf_wrData_ack = 1'b0;
      cmdIf_rdData_ack = 1'b0;
      cmdIf_ack        = cmdIf_req && ($urandom_range(99) < ackPct);
      src_valid        = ($urandom_range(99) < srcPct);
      src_data         = (srcIdx < len) ? srcWords[srcIdx] : $urandom;
      if (prevRdAck && rdIdx < len) begin
        cmdIf_rdData = rdWords[rdIdx];
        rdIdx++;
      end else begin
        cmdIf_rdData = $urandom;
      end
      #1;
      cmdIf_wrData_ack = cmdIf_wrData_req && (acked < len) && ($urandom_range(99) < ackPct);
      cmdIf_rdData_ack = cmdIf_rdData_req && (acked < len) && ($urandom_range(99) < ackPct);
      if (abortAfter >= 0 && !aborted && cmdIf_trEn && !cmdIf_req && acked == abortAfter) begin
        abort   = 1'b1;
        aborted = 1'b1;
        lastEvt = cyc;
      end
      #1;
      if (src_ready) srcIdx++;
      if (cmdIf_wrData_ack) begin
        gotWords.push_back(cmdIf_wrData);
        acked++;
        lastEvt = cyc;
      end
      if (cmdIf_rdData_ack) begin
        acked++;
        lastEvt = cyc;
      end
      prevRdAck = cmdIf_rdData_ack;
      if (dst_valid) dstWords.push_back(dst_data);
      if ((cmdIf_trEn || done) && (cmdIf_addr !== addr || cmdIf_wrRd !== wr)) addrBad = 1'b1;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
        gotErr  = err;
        endBad  = cmdIf_trEn | cmdIf_req | cmdIf_wrData_req | cmdIf_rdData_req;
        endDst  = dst_valid;
      end
      tick();
      cyc++;
    end
    idleInputs();
    #1;
    // A trailing read word acked in the END-bound cycle shows up now only if dst_valid lags.
    if (dst_valid) dstWords.push_back(dst_data);

    check({name, "_done_once"}, doneCnt, 1);
    check({name, "_done_cycle"}, doneCyc, lastEvt + 1);
    check({name, "_err"}, gotErr, expErr);
    check({name, "_end_quiet"}, endBad, 0);
    check({name, "_addr_stable"}, addrBad, 0);
    check({name, "_idle_after"}, busy, 0);
    if (abortAfter < 0) check({name, "_ack_count"}, acked, len);
    if (ackPct == 100 && srcPct == 100 && abortAfter < 0)
      check({name, "_min_duration"}, doneCyc, len + 2);
    if (wr) begin
      check({name, "_src_ready_cnt"}, srcIdx, acked);
      check({name, "_wr_words"}, gotWords.size(), acked);
      for (int i = 0; i < gotWords.size() && i < len; i++)
        check($sformatf("%s_wr_word%0d", name, i), gotWords[i], srcWords[i]);
    end else begin
      check({name, "_rd_words"}, dstWords.size(), acked);
      for (int i = 0; i < dstWords.size() && i < len; i++)
        check($sformatf("%s_rd_word%0d", name, i), dstWords[i], rdWords[i]);
      if (abortAfter < 0) check({name, "_last_dst_in_end"}, endDst, 1);
    end
    tick();
  endtask

  initial begin
    int reqCnt;
    int n;
    bit seenDone;

    vectors     = 0;
    miscompares = 0;
    idleInputs();

    // Reset state
    sysRst_n = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", {busy, done, err, cmdIf_trEn, cmdIf_req, cmdIf_wrRd, src_ready,
                       dst_valid, cmdIf_wrData_req, cmdIf_rdData_req}, 0);
    check("rst_addr", cmdIf_addr, 0);
    check("rst_data", {dst_data, cmdIf_wrData}, 0);
    #2;
    sysRst_n = 1'b1;
    tick();
    check("post_rst_idle", {busy, done, err}, 0);

    // Directed write and read bursts with an immediately acking responder
    runBurst(32'h100, 1'b1, 4, -1, 100, 100, 1'b1, "wr4");
    runBurst(32'h200, 1'b0, 3, -1, 100, 100, 1'b1, "rd3");

    // Abort after two of five write words; next start must be accepted
    runBurst(32'h300, 1'b1, 5, 2, 100, 100, 1'b0, "abort_wr");

    // Zero length: done at cycle 1, err cleared, no command activity
    start      = 1'b1;
    start_addr = 32'h40;
    start_wrRd = 1'b1;
    start_len  = '0;
    tick();
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_err", err, 0);
    check("len0_nocmd", {cmdIf_req, cmdIf_trEn}, 0);
    tick();
    check("len0_idle", {busy, done, cmdIf_req}, 0);

    // Ack timeout: address phase never acknowledged
    start      = 1'b1;
    start_addr = 32'h500;
    start_wrRd = 1'b1;
    start_len  = 11'd2;
    tick();
    start    = 1'b0;
    reqCnt   = 0;
    seenDone = 1'b0;
    n        = 0;
    while (!seenDone && n < 1200) begin
      if (cmdIf_req) reqCnt++;
      if (done) begin
        seenDone = 1'b1;
        check("tmo_err", err, 2'b01);
        check("tmo_end_trEn", cmdIf_trEn, 0);
      end
      tick();
      n++;
    end
    check("tmo_done_seen", seenDone, 1);
    check("tmo_addr_cycles", reqCnt, 1023);
    tick();

    // Randomized bursts against the responder model
    for (int b = 0; b < 8; b++) begin
      int  len;
      int  ab;
      bit  wr;
      len = $urandom_range(12, 1);
      wr  = $urandom_range(1);
      ab  = ($urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
      runBurst($urandom & 32'hFFFF_FFFC, wr, len, ab, $urandom_range(100, 40),
               $urandom_range(100, 50), 1'b0, $sformatf("rnd%0d", b));
    end

    // Start while busy is ignored; reset mid-read drops everything at once
    start      = 1'b1;
    start_addr = 32'h600;
    start_wrRd = 1'b0;
    start_len  = 11'd5;
    tick();
    start_addr = 32'h999;
    start_wrRd = 1'b1;
    start_len  = '0;
    tick();
    start = 1'b0;
    check("busy_start_addr", cmdIf_addr, 32'h600);
    check("busy_start_ctrl", {cmdIf_req, cmdIf_trEn, cmdIf_wrRd, done}, 4'b1100);
    cmdIf_ack = 1'b1;
    tick();
    cmdIf_ack = 1'b0;
    check("rd_phase_req", cmdIf_rdData_req, 1);
    cmdIf_rdData_ack = 1'b1;
    tick();
    cmdIf_rdData = 32'hDEAD_BEEF;
    #1;
    check("pre_rst_dst_valid", dst_valid, 1);
    #1;
    sysRst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {busy, done, err, cmdIf_trEn, cmdIf_req, cmdIf_wrRd,
                             cmdIf_rdData_req, dst_valid, src_ready}, 0);
    check("async_rst_data", {cmdIf_addr, dst_data}, 0);
    idleInputs();
    tick();
    sysRst_n = 1'b1;
    tick();
    check("rst_release_idle", {busy, done}, 0);

    runBurst(32'h700, 1'b1, 3, -1, 100, 100, 1'b0, "recover_wr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
